// File: rtl/tb_irq_pkg.sv
// Shared encodings for the interrupt stimulus generator:
// channel states, config selectors, channel modes and LFSR taps.
package tb_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_HOLD  = 2'd3
    } chan_state_t;

    typedef enum logic [1:0] {
        SEL_CTRL   = 2'd0,
        SEL_PERIOD = 2'd1,
        SEL_WIDTH  = 2'd2,
        SEL_RSVD   = 2'd3
    } cfg_sel_t;

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'd0,
        MODE_RANDOM   = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_WFI      = 2'd3
    } irq_mode_t;

    // Taps 16,14,13,11 map to bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tb_irq_chan.sv
// One interrupt stimulus channel: config registers, delay counter
// and the IDLE/ARM/COUNT/HOLD sequencer driving a registered line.
module tb_irq_chan
    import tb_irq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [1:0]       sel,
    input  logic [CNT_W-1:0] wdata,
    input  logic [CNT_W-1:0] rnd,
    input  logic             ack,
    input  logic             wfi_rise,
    output logic             irq,
    output logic             hold_enter
);

    chan_state_t      state_q;
    irq_mode_t        mode_q;
    irq_mode_t        wr_mode;
    logic             en_q;
    logic             level_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hold_q;
    logic [3:0]       ctrl_bits;
    logic             ctrl_wr;
    logic             hold_done;
    logic [CNT_W-1:0] hold_len;
    logic [CNT_W-1:0] load_wr;
    logic [CNT_W-1:0] load_re;

    assign ctrl_bits  = 4'(wdata);
    assign wr_mode    = irq_mode_t'(ctrl_bits[2:1]);
    assign ctrl_wr    = we && (cfg_sel_t'(sel) == SEL_CTRL);
    assign hold_len   = (width_q == '0) ? CNT_W'(1) : width_q;
    assign load_wr    = (wr_mode == MODE_RANDOM) ? (rnd & period_q) : period_q;
    assign load_re    = (mode_q == MODE_RANDOM) ? (rnd & period_q) : period_q;
    assign hold_done  = level_q ? ack : (hold_q <= CNT_W'(1));
    // A ctrl write wins over the sequencer, so it also cancels an entry
    assign hold_enter = (state_q == ST_COUNT) && en_q && (cnt_q == '0) && !ctrl_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_PERIODIC;
            en_q     <= 1'b0;
            level_q  <= 1'b0;
            period_q <= '0;
            width_q  <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            irq      <= 1'b0;
        end else begin
            if (we && cfg_sel_t'(sel) == SEL_PERIOD) period_q <= wdata;
            if (we && cfg_sel_t'(sel) == SEL_WIDTH)  width_q  <= wdata;
            if (ctrl_wr) begin
                en_q    <= ctrl_bits[0];
                mode_q  <= wr_mode;
                level_q <= ctrl_bits[3];
                irq     <= 1'b0;
                if (!ctrl_bits[0]) begin
                    state_q <= ST_IDLE;
                end else if (wr_mode == MODE_WFI) begin
                    state_q <= ST_ARM;
                end else begin
                    state_q <= ST_COUNT;
                    cnt_q   <= load_wr;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_ARM: begin
                        if (wfi_rise) begin
                            state_q <= ST_COUNT;
                            cnt_q   <= period_q;
                        end
                    end
                    ST_COUNT: begin
                        if (hold_enter) begin
                            state_q <= ST_HOLD;
                            irq     <= 1'b1;
                            hold_q  <= hold_len;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (hold_done) begin
                            irq <= 1'b0;
                            unique case (mode_q)
                                MODE_PERIODIC, MODE_RANDOM: begin
                                    state_q <= ST_COUNT;
                                    cnt_q   <= load_re;
                                end
                                MODE_ONESHOT: begin
                                    state_q <= ST_IDLE;
                                    en_q    <= 1'b0;
                                end
                                MODE_WFI: begin
                                    state_q <= ST_ARM;
                                end
                            endcase
                        end else if (!level_q) begin
                            hold_q <= hold_q - CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/tb_irq_stim_gen.sv
// Multi-channel interrupt stimulus generator with a shared LFSR,
// WFI rising-edge detect and a saturating assertion counter.
module tb_irq_stim_gen
    import tb_irq_pkg::*;
#(
    parameter int          CH_NUM    = 8,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              tb_clk,
    input  logic              tb_rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_sel,
    input  logic [CNT_W-1:0]  cfg_wdata,
    input  logic [CH_NUM-1:0] irq_ack,
    input  logic              core_wfi,
    output logic [CH_NUM-1:0] irq_o,
    output logic [31:0]       irq_cnt
);

    logic [15:0]       lfsr_q;
    logic              wfi_q;
    logic              wfi_rise;
    logic [31:0]       cnt_q;
    logic [CH_NUM-1:0] enter;
    logic [32:0]       enter_sum;
    logic [32:0]       cnt_sum;

    assign wfi_rise = core_wfi && !wfi_q;
    assign irq_cnt  = cnt_q;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        tb_irq_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk       (tb_clk),
            .rst_n     (tb_rst_n),
            .we        (cfg_we && (cfg_ch == CH_W'(i))),
            .sel       (cfg_sel),
            .wdata     (cfg_wdata),
            .rnd       (lfsr_q[CNT_W-1:0]),
            .ack       (irq_ack[i]),
            .wfi_rise  (wfi_rise),
            .irq       (irq_o[i]),
            .hold_enter(enter[i])
        );
    end

    // Carry out of bit 31 means the count would wrap: clamp instead
    always_comb begin
        enter_sum = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            enter_sum = enter_sum + 33'(enter[i]);
        end
        cnt_sum = {1'b0, cnt_q} + enter_sum;
    end

    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            lfsr_q <= LFSR_SEED;
            wfi_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            wfi_q  <= core_wfi;
            cnt_q  <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

endmodule

// File: doc/tb_irq_stim_gen.md
TB_IRQ_STIM_GEN -- requirements
Module: tb_irq_stim_gen

Interface
REQ-001 SHALL have parameter CH_NUM, default 8: number of independent interrupt channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 16: delay/width counter width (1..16).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1: non-zero LFSR reset value.
REQ-004 SHALL have port tb_clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port tb_rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port cfg_we, input, 1: configuration write strobe.
REQ-007 SHALL have port cfg_ch, input, $clog2(CH_NUM) (min 1): target channel.
REQ-008 SHALL have port cfg_sel, input, 2: 0 = ctrl, 1 = period, 2 = width, 3 = reserved (write ignored).
REQ-009 SHALL have port cfg_wdata, input, CNT_W: write data. ctrl: bit0 en, bits2:1 mode (0 periodic, 1 random, 2 one-shot, 3 wfi), bit3 level.
REQ-010 SHALL have port irq_ack, input, CH_NUM: per-channel acknowledge.
REQ-011 SHALL have port core_wfi, input, 1: core-in-WFI indication.
REQ-012 SHALL have port irq_o, output, CH_NUM: registered interrupt lines.
REQ-013 SHALL have port irq_cnt, output, 32: total assertion events, saturating.

Function
REQ-014 Each channel SHALL run an FSM with states IDLE, ARM, COUNT and HOLD; irq_o[i] SHALL be high exactly while channel i is in HOLD.
REQ-015 A ctrl write with en=1 SHALL move the channel on the next edge to COUNT (modes 0-2), or to ARM (mode 3); the load value is as defined in REQ-016.
REQ-016 The COUNT load value SHALL be period for modes 0, 2 and 3, and ({lfsr} & period) for mode 1; the counter SHALL decrement each cycle, and the channel SHALL enter HOLD on the edge after it reads 0, so the delay is load+1 cycles.
REQ-017 ARM SHALL move to COUNT on a core_wfi rising edge (previous-cycle sample 0, current sample 1).
REQ-018 Level mode (level=1): HOLD SHALL persist until irq_ack[i]=1; irq_o SHALL drop on the following edge.
REQ-019 Pulse mode (level=0): HOLD SHALL last max(width,1) cycles; irq_ack SHALL be ignored.
REQ-020 On HOLD exit: mode 0/1 SHALL reload and go to COUNT; mode 2 SHALL go to IDLE and clear en; mode 3 SHALL return to ARM.
REQ-021 A ctrl write with en=0 SHALL force the channel to IDLE on the next edge and drop irq_o, whatever the current state.
REQ-022 Period and width writes SHALL take effect at the next load and SHALL NOT disturb a running count.
REQ-023 irq_ack to a channel not in HOLD SHALL be ignored.
REQ-024 The shared LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing every cycle; its low CNT_W bits SHALL be used.
REQ-025 irq_cnt SHALL add the number of channels entering HOLD per cycle, saturating at 32'hFFFF_FFFF.

Reset
REQ-026 On tb_rst_n low, the following SHALL hold immediately: all channels in IDLE; ctrl, period and width = 0; irq_o = 0; irq_cnt = 0; lfsr = LFSR_SEED; wfi sample = 0.
REQ-027 Reset asserted mid-HOLD SHALL drop irq_o asynchronously, with no extra count.

Structure
REQ-028 The state encodings, cfg_sel codes, mode codes and LFSR taps SHALL live in shared package tb_irq_pkg.
REQ-029 The per-channel FSM, counter and config registers SHALL be sub-module tb_irq_chan, instantiated CH_NUM times; the LFSR, wfi edge detect and irq_cnt SHALL stay at top level.

Verification
REQ-030 Periodic pulse test: ch0 period=4, width=2, mode 0, en -> irq_o[0] high 2 cycles, first rise 5 cycles after write, repeating every 7 cycles.
REQ-031 Level one-shot test: ch1 mode 2, period=0, level, en -> irq_o[1] rises next+1 cycle and holds until ack; drops one cycle after ack; no re-fire; en reads 0.
REQ-032 WFI test: ch2 mode 3, period=3; pulse core_wfi 0->1 -> irq_o[2] rises 4 cycles later; holding core_wfi high causes no second fire.
REQ-033 Random test: ch3 mode 1, period=15 -> every gap lies in 1..16 cycles and matches a reference LFSR model from LFSR_SEED.
REQ-034 Disable/reset test: en=0 during COUNT and during HOLD -> irq_o low next edge; tb_rst_n pulse mid-HOLD -> irq_o low immediately, irq_cnt=0.
REQ-035 Count test: all 8 channels enter HOLD in the same cycle -> irq_cnt += 8; preload near max -> saturates at 32'hFFFF_FFFF.
